pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator with a direct-mapped branch target buffer.
// Holds a BOOT/RUN/HALT sequencer and exposes its state on state_o for observation.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic [XLEN-1:0] pc_alu_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            fetch_ready_i,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            pred_taken_o,
  output logic [1:0]      state_o
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
  logic [1:0]           cnt_q [BTB_DEPTH];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             predict, upd_hit, fire;
  logic [XLEN-1:0]  pc_d;

  assign rd_idx  = pc_o[IDX+1:2];
  assign rd_tag  = pc_o[XLEN-1:IDX+2];
  assign wr_idx  = upd_pc_i[IDX+1:2];
  assign wr_tag  = upd_pc_i[XLEN-1:IDX+2];
  assign predict = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && cnt_q[rd_idx][1];
  assign upd_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Handshake: a fetch transfers (fire) on a cycle where pc_valid_o and
  // fetch_ready_i are both high and stall_i is low; only then does the PC advance.
  assign pc_valid_o   = (state_q == ST_RUN) && !rst;
  assign fire         = pc_valid_o && fetch_ready_i && !stall_i;
  assign pred_taken_o = pc_valid_o && predict && (pc_src_i == 2'd0);
  assign state_o      = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_i) state_d = ST_HALT;
      ST_HALT: if (pc_src_i == 2'd3) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_o;
    unique case (pc_src_i)
      2'd1:    pc_d = pc_target_i;
      2'd2:    pc_d = {pc_alu_i[XLEN-1:1], 1'b0};
      2'd3:    pc_d = trap_vec_i;
      default: begin
        if (fire && predict) pc_d = tgt_q[rd_idx];
        else if (fire)       pc_d = pc_o + XLEN'(4);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_o    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_o    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_en_i && !upd_hit && upd_taken_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload fields carry no reset; a cleared valid bit is enough to hide them.
  always_ff @(posedge clk) begin
    if (!rst && upd_en_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          cnt_q[wr_idx] <= (cnt_q[wr_idx] == 2'b11) ? 2'b11 : 2'(cnt_q[wr_idx] + 2'd1);
          tgt_q[wr_idx] <= upd_target_i;
        end else begin
          cnt_q[wr_idx] <= (cnt_q[wr_idx] == 2'b00) ? 2'b00 : 2'(cnt_q[wr_idx] - 2'd1);
        end
      end else if (upd_taken_i) begin
        tag_q[wr_idx] <= wr_tag;
        tgt_q[wr_idx] <= upd_target_i;
        cnt_q[wr_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen: inputs are driven just after the rising edge
// and outputs are compared on the falling edge of the same cycle.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src_i;
  logic [31:0] pc_target_i, pc_alu_i, trap_vec_i;
  logic        stall_i, halt_i, fetch_ready_i;
  logic        upd_en_i;
  logic [31:0] upd_pc_i, upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, pred_taken_o;
  logic [1:0]  state_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .BTB_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .pc_src_i(pc_src_i), .pc_target_i(pc_target_i),
    .pc_alu_i(pc_alu_i), .trap_vec_i(trap_vec_i), .stall_i(stall_i),
    .halt_i(halt_i), .fetch_ready_i(fetch_ready_i), .upd_en_i(upd_en_i),
    .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
    .state_o(state_o)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  src;
    logic [31:0] addr;
    logic        stall, halt, rdy;
    logic        upd_en;
    logic [31:0] upd_pc, upd_tgt;
    logic        upd_tk;
    logic [31:0] exp_pc;
    logic        exp_v, exp_pred;
  } vec_t;

  vec_t vec_q[$];

  function automatic vec_t mk(logic r, logic [1:0] src, logic [31:0] addr,
                              logic stall, logic halt, logic rdy,
                              logic ue, logic [31:0] upc, logic [31:0] utgt, logic utk,
                              logic [31:0] epc, logic ev, logic ep);
    vec_t v;
    v.rst = r; v.src = src; v.addr = addr; v.stall = stall; v.halt = halt; v.rdy = rdy;
    v.upd_en = ue; v.upd_pc = upc; v.upd_tgt = utgt; v.upd_tk = utk;
    v.exp_pc = epc; v.exp_v = ev; v.exp_pred = ep;
    return v;
  endfunction

  // Unselected redirect inputs carry distinct junk so a wrong mux leg shows up.
  task automatic apply(input vec_t v, input string tag);
    rst           = v.rst;
    pc_src_i      = v.src;
    pc_target_i   = (v.src == 2'd1) ? v.addr : 32'h0BAD_0010;
    pc_alu_i      = (v.src == 2'd2) ? v.addr : 32'h0BAD_0020;
    trap_vec_i    = (v.src == 2'd3) ? v.addr : 32'h0BAD_0030;
    stall_i       = v.stall;
    halt_i        = v.halt;
    fetch_ready_i = v.rdy;
    upd_en_i      = v.upd_en;
    upd_pc_i      = v.upd_pc;
    upd_target_i  = v.upd_tgt;
    upd_taken_i   = v.upd_tk;
    @(negedge clk);
    n_vec++;
    if (pc_o !== v.exp_pc) begin
      n_fail++;
      $display("FAIL %s pc_o: got %h expected %h", tag, pc_o, v.exp_pc);
    end
    if (pc_valid_o !== v.exp_v) begin
      n_fail++;
      $display("FAIL %s pc_valid_o: got %b expected %b", tag, pc_valid_o, v.exp_v);
    end
    if (pred_taken_o !== v.exp_pred) begin
      n_fail++;
      $display("FAIL %s pred_taken_o: got %b expected %b", tag, pred_taken_o, v.exp_pred);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply_reset_init();
    // rst src addr stall halt rdy | upd_en upd_pc upd_tgt tk | exp_pc v pred
    vec_q.push_back(mk(1, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h0,        0, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h0,        0, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h0,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h4,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h8,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'hC,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 32'hC,        1, 0));
    vec_q.push_back(mk(0, 1, 32'h100,      0, 0, 1, 0, 0, 0, 0, 32'hC,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 32'h100,      1, 0));
    vec_q.push_back(mk(0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 32'h100,      1, 0));
    vec_q.push_back(mk(0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 32'h100,      1, 0));
    vec_q.push_back(mk(0, 1, 32'h40,       1, 0, 1, 0, 0, 0, 0, 32'h100,      1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h40,       1, 0));
    vec_q.push_back(mk(0, 2, 32'h33,       0, 0, 1, 0, 0, 0, 0, 32'h44,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h32,       1, 0));
    vec_q.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 32'h32,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0));
    // BTB training at 0x20 -> 0x80, then two not-taken updates
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 0, 1, 32'h20, 32'h80, 1, 32'h0,  1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h20,       1, 1));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h80,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 1, 32'h20, 32'h0, 0, 32'h84,  1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 1, 32'h20, 32'h0, 0, 32'h84,  1, 0));
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 0, 0, 0, 0, 0, 32'h84,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h20,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h24,       1, 0));
    // retrain to 0x90; same-cycle lookup sees the pre-update counter
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 0, 1, 32'h20, 32'h90, 1, 32'h24, 1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 1, 32'h20, 32'h90, 1, 32'h20, 1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h20,       1, 1));
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 1, 0, 0, 0, 0, 32'h90,       1, 0));
    vec_q.push_back(mk(0, 1, 32'h60,       0, 0, 1, 0, 0, 0, 0, 32'h20,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h60,       1, 0));
    // halt, redirect while halted, trap back into RUN
    vec_q.push_back(mk(0, 0, 0,            0, 1, 1, 0, 0, 0, 0, 32'h64,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h68,       0, 0));
    vec_q.push_back(mk(0, 1, 32'h300,      0, 0, 1, 0, 0, 0, 0, 32'h68,       0, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h300,      0, 0));
    vec_q.push_back(mk(0, 3, 32'h200,      0, 0, 1, 0, 0, 0, 0, 32'h300,      0, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h200,      1, 0));
    // mid-stream reset after training; update during rst must be dropped
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 0, 0, 0, 0, 0, 32'h204,      1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h20,       1, 1));
    vec_q.push_back(mk(1, 1, 32'h80,       0, 0, 1, 1, 32'h40, 32'hA0, 1, 32'h20, 0, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h0,        0, 0));
    vec_q.push_back(mk(0, 1, 32'h20,       0, 0, 1, 0, 0, 0, 0, 32'h0,        1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h20,       1, 0));
    vec_q.push_back(mk(0, 1, 32'h40,       0, 0, 1, 0, 0, 0, 0, 32'h24,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h40,       1, 0));
    vec_q.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h44,       1, 0));

    for (int i = 0; i < vec_q.size(); i++) apply(vec_q[i], $sformatf("vec%0d", i));

    // Counter saturation: four taken updates must stop at 2'b11, so one
    // not-taken still predicts and a second one stops predicting.
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h20, 32'h80, 1, 32'h44, 1, 0), $sformatf("sat_train%0d", i));
    apply(mk(0, 0, 0,      0, 0, 0, 1, 32'h20, 32'h0, 0, 32'h44, 1, 0), "sat_nt1");
    apply(mk(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0,          32'h44, 1, 0), "sat_redir");
    apply(mk(0, 0, 0,      0, 0, 0, 0, 0, 0, 0,          32'h20, 1, 1), "sat_pred_hi");
    apply(mk(0, 0, 0,      0, 0, 0, 1, 32'h20, 32'h0, 0, 32'h20, 1, 1), "sat_nt2");
    apply(mk(0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          32'h20, 1, 0), "sat_pred_lo");
    apply(mk(0, 0, 0,      0, 0, 0, 0, 0, 0, 0,          32'h24, 1, 0), "sat_seq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  task automatic apply_reset_init();
    rst = 1'b1; pc_src_i = 2'd0; pc_target_i = '0; pc_alu_i = '0; trap_vec_i = '0;
    stall_i = 1'b0; halt_i = 1'b0; fetch_ready_i = 1'b1;
    upd_en_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_taken_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

endmodule
